// File: rtl/ldm_stm_pkg.sv
// ldm_stm_pkg
//   Shared types and helpers for the LDM/STM block-transfer sequencer.
//   - state_e     : sequencer FSM states
//   - PU_*        : {P,U} addressing-mode encodings
//   - R15         : register index of the PC
//   - popcount16  : number of registers in a 16-bit register list
package ldm_stm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_BEAT,
    ST_WB,
    ST_DONE
  } state_e;

  localparam logic [1:0] PU_DA = 2'b00;
  localparam logic [1:0] PU_IA = 2'b01;
  localparam logic [1:0] PU_DB = 2'b10;
  localparam logic [1:0] PU_IB = 2'b11;

  localparam logic [3:0] R15 = 4'd15;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// lowest_set_bit_encoder
//   Combinational priority encoder returning the lowest set bit of a
//   16-bit register list.
//   Ports:
//     bits  in  16  register list
//     index out 4   number of the lowest set bit (0 when bits == 0)
//     valid out 1   at least one bit set
module lowest_set_bit_encoder (
  input  logic [15:0] bits,
  output logic [3:0]  index,
  output logic        valid
);

  // Scan downwards so the last hit (lowest index) wins.
  always_comb begin
    index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (bits[i]) index = 4'(i);
    end
  end

  assign valid = |bits;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
//   Multi-cycle sequencer for ARMv4 LDM/STM block transfers. Walks the
//   register list lowest register first at ascending addresses, moving one
//   word per req/ack memory beat, then optionally writes back the base.
//   Optional feature (macro LDM_STM_ALIGN_CHECK_EN): an unaligned base
//   aborts the transfer in SETUP and raises ALIGN_FAULT together with DONE.
//   Ports:
//     CLK, RST                 clock, async active-high reset
//     START, IS_LOAD, PU_MODE,
//     WRT_BACK, BASE_REG,
//     BASE_ADDR, REG_LIST      instruction operands, sampled on START in IDLE
//     RF_ADDRS_RM / RF_RM_DATA register-file read port (STM source)
//     RF_ADDRS_RD / RF_WRT_DATA
//     / RF_WRT_ENA             register-file write port (LDM, writeback)
//     MEM_REQ, MEM_WRT_ENA,
//     MEM_ADDR, MEM_WRT_DATA,
//     MEM_RD_DATA, MEM_ACK     data memory port
//     BUSY, DONE, PC_LOADED    status to control
//     ALIGN_FAULT              only with LDM_STM_ALIGN_CHECK_EN
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             IS_LOAD,
  input  logic [1:0]       PU_MODE,
  input  logic             WRT_BACK,
  input  logic [3:0]       BASE_REG,
  input  logic [WIDTH-1:0] BASE_ADDR,
  input  logic [15:0]      REG_LIST,
  output logic [3:0]       RF_ADDRS_RM,
  input  logic [WIDTH-1:0] RF_RM_DATA,
  output logic [3:0]       RF_ADDRS_RD,
  output logic [WIDTH-1:0] RF_WRT_DATA,
  output logic             RF_WRT_ENA,
  output logic             MEM_REQ,
  output logic             MEM_WRT_ENA,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic [WIDTH-1:0] MEM_WRT_DATA,
  input  logic [WIDTH-1:0] MEM_RD_DATA,
  input  logic             MEM_ACK,
  output logic             BUSY,
  output logic             DONE,
`ifdef LDM_STM_ALIGN_CHECK_EN
  output logic             ALIGN_FAULT,
`endif
  output logic             PC_LOADED
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_e           state;
  logic             is_load_q;
  logic             wrt_back_q;
  logic [1:0]       pu_q;
  logic [3:0]       base_reg_q;
  logic [WIDTH-1:0] base_q;
  logic [15:0]      list_q;
  logic [15:0]      work_q;     // registers still to transfer

  logic [3:0]       cur;
  logic             cur_valid;
  logic [WIDTH-1:0] span;       // STEP * number of registers
  logic [WIDTH-1:0] start_addr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_en;

  lowest_set_bit_encoder u_lsb (
    .bits  (work_q),
    .index (cur),
    .valid (cur_valid)
  );

  always_comb begin
    span = STEP_W * WIDTH'(popcount16(list_q));
    case (pu_q)
      PU_IB:   start_addr = base_q + STEP_W;
      PU_DA:   start_addr = base_q - span + STEP_W;
      PU_DB:   start_addr = base_q - span;
      default: start_addr = base_q;
    endcase
    wb_data = pu_q[0] ? base_q + span : base_q - span;
    // A loaded base register keeps the loaded value.
    wb_en   = wrt_back_q && !(is_load_q && list_q[base_reg_q]);
  end

  // Store data comes straight from the combinational RF read of RF_ADDRS_RM.
  assign MEM_WRT_DATA = MEM_WRT_ENA ? RF_RM_DATA : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      is_load_q   <= 1'b0;
      wrt_back_q  <= 1'b0;
      pu_q        <= '0;
      base_reg_q  <= '0;
      base_q      <= '0;
      list_q      <= '0;
      work_q      <= '0;
      RF_ADDRS_RM <= '0;
      RF_ADDRS_RD <= '0;
      RF_WRT_DATA <= '0;
      RF_WRT_ENA  <= 1'b0;
      MEM_REQ     <= 1'b0;
      MEM_WRT_ENA <= 1'b0;
      MEM_ADDR    <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      PC_LOADED   <= 1'b0;
`ifdef LDM_STM_ALIGN_CHECK_EN
      ALIGN_FAULT <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes
      RF_WRT_ENA <= 1'b0;
      DONE       <= 1'b0;
      PC_LOADED  <= 1'b0;
`ifdef LDM_STM_ALIGN_CHECK_EN
      ALIGN_FAULT <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (START) begin
            is_load_q  <= IS_LOAD;
            wrt_back_q <= WRT_BACK;
            pu_q       <= PU_MODE;
            base_reg_q <= BASE_REG;
            base_q     <= BASE_ADDR;
            list_q     <= REG_LIST;
            work_q     <= REG_LIST;
            BUSY       <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
`ifdef LDM_STM_ALIGN_CHECK_EN
          if (base_q[1:0] != 2'b00) begin
            ALIGN_FAULT <= 1'b1;
            DONE        <= 1'b1;
            state       <= ST_DONE;
          end else
`endif
          if (cur_valid) begin
            MEM_REQ     <= 1'b1;
            MEM_WRT_ENA <= !is_load_q;
            MEM_ADDR    <= start_addr;
            RF_ADDRS_RM <= cur;
            state       <= ST_XFER;
          end else begin
            RF_WRT_ENA  <= wb_en;
            RF_ADDRS_RD <= base_reg_q;
            RF_WRT_DATA <= wb_data;
            state       <= ST_WB;
          end
        end
        ST_XFER: begin
          // Outputs hold until the beat is acknowledged.
          if (MEM_ACK) begin
            work_q      <= work_q & ~(16'd1 << cur);
            MEM_ADDR    <= MEM_ADDR + STEP_W;
            MEM_REQ     <= 1'b0;
            MEM_WRT_ENA <= 1'b0;
            RF_WRT_ENA  <= is_load_q;
            RF_ADDRS_RD <= RF_ADDRS_RM;
            RF_WRT_DATA <= MEM_RD_DATA;
            state       <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (cur_valid) begin
            MEM_REQ     <= 1'b1;
            MEM_WRT_ENA <= !is_load_q;
            RF_ADDRS_RM <= cur;
            state       <= ST_XFER;
          end else begin
            RF_WRT_ENA  <= wb_en;
            RF_ADDRS_RD <= base_reg_q;
            RF_WRT_DATA <= wb_data;
            state       <= ST_WB;
          end
        end
        ST_WB: begin
          DONE      <= 1'b1;
          PC_LOADED <= is_load_q && list_q[R15];
          state     <= ST_DONE;
        end
        ST_DONE: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer
//   Directed bench for ldm_stm_sequencer. Expected memory beats and
//   register-file writes are queued when an operation is launched and
//   compared as the sequencer produces them.
module tb_ldm_stm_sequencer;
  import ldm_stm_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        IS_LOAD = 1'b0;
  logic [1:0]  PU_MODE = 2'b00;
  logic        WRT_BACK = 1'b0;
  logic [3:0]  BASE_REG = 4'd0;
  logic [31:0] BASE_ADDR = 32'd0;
  logic [15:0] REG_LIST = 16'd0;
  logic [3:0]  RF_ADDRS_RM;
  logic [31:0] RF_RM_DATA;
  logic [3:0]  RF_ADDRS_RD;
  logic [31:0] RF_WRT_DATA;
  logic        RF_WRT_ENA;
  logic        MEM_REQ;
  logic        MEM_WRT_ENA;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WRT_DATA;
  logic [31:0] MEM_RD_DATA = 32'd0;
  logic        MEM_ACK = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic        PC_LOADED;
`ifdef LDM_STM_ALIGN_CHECK_EN
  logic        ALIGN_FAULT;
`endif

  logic [31:0] rf [16];
  assign RF_RM_DATA = rf[RF_ADDRS_RM];

  always #5 CLK = ~CLK;

  ldm_stm_sequencer #(.WIDTH(32), .STEP(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .IS_LOAD      (IS_LOAD),
    .PU_MODE      (PU_MODE),
    .WRT_BACK     (WRT_BACK),
    .BASE_REG     (BASE_REG),
    .BASE_ADDR    (BASE_ADDR),
    .REG_LIST     (REG_LIST),
    .RF_ADDRS_RM  (RF_ADDRS_RM),
    .RF_RM_DATA   (RF_RM_DATA),
    .RF_ADDRS_RD  (RF_ADDRS_RD),
    .RF_WRT_DATA  (RF_WRT_DATA),
    .RF_WRT_ENA   (RF_WRT_ENA),
    .MEM_REQ      (MEM_REQ),
    .MEM_WRT_ENA  (MEM_WRT_ENA),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WRT_DATA (MEM_WRT_DATA),
    .MEM_RD_DATA  (MEM_RD_DATA),
    .MEM_ACK      (MEM_ACK),
    .BUSY         (BUSY),
    .DONE         (DONE),
`ifdef LDM_STM_ALIGN_CHECK_EN
    .ALIGN_FAULT  (ALIGN_FAULT),
`endif
    .PC_LOADED    (PC_LOADED)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } rfw_t;

  beat_t exp_beats[$];
  rfw_t  exp_rf[$];

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int beats_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [31:0] rdata);
    beat_t b;
    b.addr = addr; b.we = we; b.wdata = wdata; b.rdata = rdata;
    exp_beats.push_back(b);
  endtask

  task automatic push_rf(input logic [3:0] addr, input logic [31:0] data);
    rfw_t w;
    w.addr = addr; w.data = data;
    exp_rf.push_back(w);
  endtask

  // Memory responder: checks each request against the next expected beat
  // every cycle it is pending (so it also catches unstable outputs) and
  // acknowledges after ack_delay wait cycles.
  always @(negedge CLK) begin
    if (RST || !MEM_REQ) begin
      MEM_ACK  = 1'b0;
      wait_cnt = 0;
    end else if (exp_beats.size() == 0) begin
      chk("unexpected_mem_req", MEM_REQ, 1'b0);
      MEM_ACK = 1'b1;
    end else begin
      chk("mem_addr", MEM_ADDR, exp_beats[0].addr);
      chk("mem_we", MEM_WRT_ENA, exp_beats[0].we);
      if (exp_beats[0].we) chk("mem_wdata", MEM_WRT_DATA, exp_beats[0].wdata);
      if (wait_cnt == ack_delay) begin
        MEM_ACK     = 1'b1;
        MEM_RD_DATA = exp_beats[0].rdata;
        void'(exp_beats.pop_front());
        beats_done++;
        wait_cnt = 0;
      end else begin
        MEM_ACK = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Register-file write monitor
  always @(negedge CLK) begin : rf_mon
    rfw_t w;
    if (!RST && RF_WRT_ENA) begin
      if (exp_rf.size() == 0) begin
        chk("unexpected_rf_wr", RF_WRT_ENA, 1'b0);
      end else begin
        w = exp_rf.pop_front();
        chk("rf_wr_addr", RF_ADDRS_RD, w.addr);
        chk("rf_wr_data", RF_WRT_DATA, w.data);
        $display("rf write R%0d = %h", RF_ADDRS_RD, RF_WRT_DATA);
      end
    end
  end

  // Launch one operation and wait for DONE. Cycle count starts at 1 for
  // the cycle START is presented. With poke set, a second START with
  // different operands is presented mid-operation and must be ignored.
  task automatic run_op(input string name, input logic ld, input logic [1:0] pu,
                        input logic wb, input logic [3:0] breg, input logic [31:0] base,
                        input logic [15:0] list, input int exp_cycles,
                        input logic exp_pc, input logic poke);
    int cycles;
    @(negedge CLK);
    IS_LOAD = ld; PU_MODE = pu; WRT_BACK = wb; BASE_REG = breg;
    BASE_ADDR = base; REG_LIST = list; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    cycles = 2;
    chk({name, "_busy"}, BUSY, 1'b1);
    while (!DONE && cycles < 300) begin
      if (poke && cycles == 4) begin
        START = 1'b1; IS_LOAD = !ld; REG_LIST = 16'hFFFF;
      end else begin
        START = 1'b0; IS_LOAD = ld; REG_LIST = list;
      end
      @(negedge CLK);
      cycles++;
    end
    START = 1'b0; IS_LOAD = ld; REG_LIST = list;
    chk({name, "_done"}, DONE, 1'b1);
    chk({name, "_latency"}, cycles, exp_cycles);
    chk({name, "_pc_loaded"}, PC_LOADED, exp_pc);
`ifdef LDM_STM_ALIGN_CHECK_EN
    chk({name, "_align_fault"}, ALIGN_FAULT, 1'b0);
`endif
    chk({name, "_beats_left"}, exp_beats.size(), 0);
    chk({name, "_rf_left"}, exp_rf.size(), 0);
    @(negedge CLK);
    chk({name, "_done_pulse"}, DONE, 1'b0);
    chk({name, "_idle"}, BUSY, 1'b0);
    $display("op %s: %0d cycles, pc_loaded=%0b", name, cycles, exp_pc);
  endtask

  initial begin
    int n;
    int b0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[0] = 32'hD0; rf[1] = 32'hA; rf[2] = 32'hB; rf[3] = 32'hC;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_mem_req", MEM_REQ, 1'b0);
    chk("rst_mem_addr", MEM_ADDR, 32'h0);
    chk("rst_rf_we", RF_WRT_ENA, 1'b0);
    chk("rst_pc", PC_LOADED, 1'b0);
    RST = 1'b0;

    // STM IA, R1..R3, stray START mid-operation
    rf[1] = 32'hA; rf[2] = 32'hB; rf[3] = 32'hC;
    push_beat(32'h1000, 1'b1, 32'hA, 32'h0);
    push_beat(32'h1004, 1'b1, 32'hB, 32'h0);
    push_beat(32'h1008, 1'b1, 32'hC, 32'h0);
    run_op("stm_ia", 1'b0, PU_IA, 1'b0, 4'd0, 32'h1000, 16'h000E, 10, 1'b0, 1'b1);

    // LDM DB with writeback, R0, R1, R15; base R13
    push_beat(32'h1FF4, 1'b0, 32'h0, 32'h11);
    push_beat(32'h1FF8, 1'b0, 32'h0, 32'h22);
    push_beat(32'h1FFC, 1'b0, 32'h0, 32'h33);
    push_rf(4'd0, 32'h11);
    push_rf(4'd1, 32'h22);
    push_rf(4'd15, 32'h33);
    push_rf(4'd13, 32'h1FF4);
    run_op("ldm_db_wb", 1'b1, PU_DB, 1'b1, 4'd13, 32'h2000, 16'h8003, 10, 1'b1, 1'b0);

    // LDM IA with base in list: loaded value wins, no writeback
    push_beat(32'h3000, 1'b0, 32'h0, 32'h55);
    push_rf(4'd2, 32'h55);
    run_op("ldm_ia_base_in_list", 1'b1, PU_IA, 1'b1, 4'd2, 32'h3000, 16'h0004, 6, 1'b0, 1'b0);

    // Empty list, STM IB with writeback
    push_rf(4'd4, 32'h40);
    run_op("empty_list", 1'b0, PU_IB, 1'b1, 4'd4, 32'h40, 16'h0000, 4, 1'b0, 1'b0);

    // STM DA with writeback, base register stored with its original value
    rf[4] = 32'h44444444; rf[5] = 32'h100;
    push_beat(32'hFC, 1'b1, 32'h44444444, 32'h0);
    push_beat(32'h100, 1'b1, 32'h100, 32'h0);
    push_rf(4'd5, 32'hF8);
    run_op("stm_da_base_in_list", 1'b0, PU_DA, 1'b1, 4'd5, 32'h100, 16'h0030, 8, 1'b0, 1'b0);

    // STM IB across the top of the address space
    rf[0] = 32'hD0; rf[1] = 32'hD1;
    push_beat(32'hFFFFFFFC, 1'b1, 32'hD0, 32'h0);
    push_beat(32'h00000000, 1'b1, 32'hD1, 32'h0);
    push_rf(4'd7, 32'h0);
    run_op("stm_ib_wrap", 1'b0, PU_IB, 1'b1, 4'd7, 32'hFFFFFFF8, 16'h0003, 8, 1'b0, 1'b0);

    // Delayed acks, reset during the second beat
    ack_delay = 3;
    push_beat(32'h500, 1'b0, 32'h0, 32'h77);
    push_beat(32'h504, 1'b0, 32'h0, 32'h88);
    push_rf(4'd0, 32'h77);
    push_rf(4'd1, 32'h88);
    b0 = beats_done;
    @(negedge CLK);
    IS_LOAD = 1'b1; PU_MODE = PU_IA; WRT_BACK = 1'b0; BASE_REG = 4'd9;
    BASE_ADDR = 32'h500; REG_LIST = 16'h0003; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    while (!(beats_done == b0 + 1 && MEM_REQ) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_second_beat_req", MEM_REQ, 1'b1);
    chk("abort_first_rf_written", exp_rf.size(), 1);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_mem_req", MEM_REQ, 1'b0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_mem_we", MEM_WRT_ENA, 1'b0);
    chk("abort_rf_we", RF_WRT_ENA, 1'b0);
    chk("abort_done", DONE, 1'b0);
    $display("reset asserted mid-transfer");
    @(negedge CLK);
    #2 RST = 1'b0;
    exp_beats.delete();
    exp_rf.delete();
    ack_delay = 0;

    // Normal operation after the abort
    push_beat(32'h600, 1'b0, 32'h0, 32'h99);
    push_beat(32'h604, 1'b0, 32'h0, 32'hAA);
    push_rf(4'd0, 32'h99);
    push_rf(4'd8, 32'hAA);
    run_op("ldm_after_reset", 1'b1, PU_IA, 1'b0, 4'd3, 32'h600, 16'h0101, 8, 1'b0, 1'b0);

`ifdef LDM_STM_ALIGN_CHECK_EN
    // Unaligned base: no beats, no RF writes, ALIGN_FAULT with DONE
    @(negedge CLK);
    IS_LOAD = 1'b1; PU_MODE = PU_IA; WRT_BACK = 1'b1; BASE_REG = 4'd3;
    BASE_ADDR = 32'h1002; REG_LIST = 16'h0003; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 2;
    while (!DONE && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("align_done", DONE, 1'b1);
    chk("align_latency", n, 3);
    chk("align_fault", ALIGN_FAULT, 1'b1);
    chk("align_pc_loaded", PC_LOADED, 1'b0);
    @(negedge CLK);
    chk("align_fault_pulse", ALIGN_FAULT, 1'b0);
    chk("align_idle", BUSY, 1'b0);
    $display("op align_fault: %0d cycles", n);
`else
    // Unaligned base passes straight through to the memory address
    push_beat(32'h1002, 1'b1, 32'hD0, 32'h0);
    run_op("unaligned_pass", 1'b0, PU_IA, 1'b0, 4'd3, 32'h1002, 16'h0001, 6, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
